register_ld_clr_inc_shr: RTL and testbench
==========================================

// Module: register_ld_clr_inc_shr
//
// PURPOSE
//   General-purpose N-bit (default 4) data register with synchronous clear,
//   parallel load, increment and logical shift-right operations.
//   The bit shifted out of the LSB is captured in a carry flag.
//   Intended as a datapath building block: accumulator, counter or shifter
//   stage driven by a controller's one-per-cycle micro-ops.
//
// PARAMETERS
//   WIDTH   4   register width in bits (>= 2)
//
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous reset, active-high
//   clr          in   1      synchronous clear request
//   ld           in   1      synchronous parallel load of data_in
//   inc          in   1      synchronous increment by 1
//   shr          in   1      synchronous logical shift right by 1
//   data_in      in   WIDTH  parallel load value
//   data_out     out  WIDTH  current register contents (registered)
//   right_carry  out  1      last bit shifted out of LSB (registered)
//
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-high.
//   - rst=1: data_out=0 and right_carry=0 immediately, independent of clk.
//     Both hold while rst is high. The first update follows the first
//     rising edge after rst deasserts.
//   - Controls may be asserted in any combination.
//   - Exactly one operation per rising edge, chosen by fixed priority
//     clr > ld > inc > shr:
//       clr : data_out<=0, right_carry<=0
//       ld  : data_out<=data_in, right_carry holds
//       inc : data_out<=data_out+1 modulo 2^WIDTH, right_carry holds
//       shr : data_out<={1'b0, data_out[WIDTH-1:1]}, right_carry<=data_out[0]
//       none: data_out and right_carry hold
//   - Wrap-around: inc from all-ones yields 0. There is no overflow flag,
//     and right_carry is not affected by the wrap.
//   - Shift-in is always 0 (logical shift; no arithmetic or serial input).
//   - data_in is exactly WIDTH bits. Any wider value a driver computes is
//     truncated at the port, e.g. 16 loads as 0 when WIDTH=4.
//   - Latency: each result is visible on data_out/right_carry one edge after
//     the controls are sampled. No combinational path from inputs to outputs.
//   - Reset asserted mid-operation overrides any pending op. Controls
//     sampled on the edge coincident with rst are ignored.
//   - X-free: all state elements are reset; no latches.
//
// TESTING
//   1. rst pulse with data_out=0xA, right_carry=1 (no edge) ->
//      both read 0 immediately and hold until rst falls.
//   2. ld=1, data_in=0x9, then shr x4 -> data_out 0x4,0x2,0x1,0x0;
//      right_carry 1,0,0,1.
//   3. ld 0xE, then inc x3 -> data_out 0xF, 0x0, 0x1 (wrap);
//      right_carry unchanged throughout.
//   4. Priority: clr=ld=inc=shr=1 with data_out=0x7 -> 0x0, rc=0.
//      ld=inc=shr=1, data_in=0x5 -> 0x5.
//      inc=shr=1 from 0x5 -> 0x6, rc unchanged.
//   5. All controls 0 for 5 cycles after ld 0xC -> data_out stays 0xC,
//      right_carry unchanged.
//   6. Randomized: 100+ cycles of random clr/ld/inc/shr/data_in vs a
//      reference model using the priority above; data_out and right_carry
//      must match every cycle, including at least one mid-run rst pulse.

Source files
------------

// File: rtl/register_ld_clr_inc_shr.sv
`default_nettype none
// ============================================================================
// Module      : register_ld_clr_inc_shr
// Description : WIDTH-bit datapath register supporting synchronous clear,
//               parallel load, increment and logical shift-right. One
//               operation is applied per rising edge, in the priority order
//               clr > ld > inc > shr. The bit shifted out of the LSB is
//               kept in right_carry.
// Revision    : 1.0 - initial release
// ============================================================================
module register_ld_clr_inc_shr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic             inc,
    input  logic             shr,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             right_carry
);

    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_data;
    logic             r_carry;
    logic [WIDTH-1:0] w_next_data;
    logic             w_next_carry;

    // Select the single operation for this edge; lower-priority controls are ignored.
    always_comb begin
        w_next_data  = r_data;
        w_next_carry = r_carry;
        if (clr) begin
            w_next_data  = c_zero;
            w_next_carry = 1'b0;
        end else if (ld) begin
            w_next_data  = data_in;
        end else if (inc) begin
            // Wraps silently from all-ones to zero; carry flag is shift-only.
            w_next_data  = r_data + c_one;
        end else if (shr) begin
            w_next_data  = {1'b0, r_data[WIDTH-1:1]};
            w_next_carry = r_data[0];
        end
    end

    // State register; reset clears both outputs immediately, independent of clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= c_zero;
            r_carry <= 1'b0;
        end else begin
            r_data  <= w_next_data;
            r_carry <= w_next_carry;
        end
    end

    assign data_out    = r_data;
    assign right_carry = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_register_ld_clr_inc_shr.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_ld_clr_inc_shr
// Description : Self-checking bench for register_ld_clr_inc_shr: directed
//               scenarios with literal expectations plus randomized controls
//               compared every cycle against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_ld_clr_inc_shr;

    localparam int WIDTH = 4;
    localparam int MOD   = 1 << WIDTH;

    logic             clk;
    logic             rst;
    logic             clr;
    logic             ld;
    logic             inc;
    logic             shr;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             right_carry;

    // Full-width value the driver "computes"; only the low WIDTH bits reach the port.
    logic [7:0]       din_wide;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 0;

    int m_data;
    int m_carry;

    register_ld_clr_inc_shr #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .ld          (ld),
        .inc         (inc),
        .shr         (shr),
        .data_in     (data_in),
        .data_out    (data_out),
        .right_carry (right_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign data_in = din_wide[WIDTH-1:0];

    // Reference model: integer arithmetic over the priority rules.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data  <= 0;
            m_carry <= 0;
        end else if (clr) begin
            m_data  <= 0;
            m_carry <= 0;
        end else if (ld) begin
            m_data  <= int'(din_wide) % MOD;
        end else if (inc) begin
            m_data  <= (m_data + 1) % MOD;
        end else if (shr) begin
            m_data  <= m_data / 2;
            m_carry <= m_data % 2;
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    endtask

    // Per-cycle comparison of DUT against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model data_out", int'(data_out), m_data);
            check("model right_carry", int'(right_carry), m_carry);
        end
    end

    // Apply one set of controls for exactly one rising edge; return #1 after it.
    task automatic do_op(input bit c, input bit l, input bit i, input bit s, input logic [7:0] d);
        @(negedge clk);
        #1;
        clr = c; ld = l; inc = i; shr = s; din_wide = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_regs(input string name, input int d, input int rc);
        check({name, " data"}, int'(data_out), d);
        check({name, " rc"}, int'(right_carry), rc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clr = 0; ld = 0; inc = 0; shr = 0; din_wide = '0;
        #1;
        expect_regs("reset", 0, 0);
        #11;
        rst = 1'b0;
        cmp_en = 1'b1;

        // 1: async reset with no clock edge
        do_op(0, 1, 0, 0, 8'h3);  expect_regs("ld3", 3, 0);
        do_op(0, 0, 0, 1, 8'h0);  expect_regs("shr from 3", 1, 1);
        do_op(0, 1, 0, 0, 8'hA);  expect_regs("ld A keeps rc", 10, 1);
        #2;
        rst = 1'b1;
        #1;
        expect_regs("async rst", 0, 0);
        @(posedge clk); #1;
        expect_regs("rst hold over edge", 0, 0);
        @(negedge clk); #1;
        rst = 1'b0;
        ld = 0;
        #1;
        expect_regs("after rst release", 0, 0);

        // 2: load 9 and shift four times
        do_op(0, 1, 0, 0, 8'h9);  expect_regs("ld9", 9, 0);
        do_op(0, 0, 0, 1, 8'h0);  expect_regs("shr1", 4, 1);
        do_op(0, 0, 0, 1, 8'h0);  expect_regs("shr2", 2, 0);
        do_op(0, 0, 0, 1, 8'h0);  expect_regs("shr3", 1, 0);
        do_op(0, 0, 0, 1, 8'h0);  expect_regs("shr4", 0, 1);

        // 3: increment through wrap, carry untouched
        do_op(0, 1, 0, 0, 8'hE);  expect_regs("ldE", 14, 1);
        do_op(0, 0, 1, 0, 8'h0);  expect_regs("inc1", 15, 1);
        do_op(0, 0, 1, 0, 8'h0);  expect_regs("inc wrap", 0, 1);
        do_op(0, 0, 1, 0, 8'h0);  expect_regs("inc3", 1, 1);

        // 4: priority
        do_op(0, 1, 0, 0, 8'h7);  expect_regs("ld7", 7, 1);
        do_op(1, 1, 1, 1, 8'hF);  expect_regs("clr wins", 0, 0);
        do_op(0, 1, 1, 1, 8'h5);  expect_regs("ld wins", 5, 0);
        do_op(0, 0, 1, 1, 8'h0);  expect_regs("inc over shr", 6, 0);

        // 5: idle holds
        do_op(0, 1, 0, 0, 8'hC);
        for (int k = 0; k < 5; k++) do_op(0, 0, 0, 0, 8'h3);
        expect_regs("idle hold", 12, 0);

        // data_in wider than the port is truncated
        do_op(0, 1, 0, 0, 8'h10); expect_regs("ld 16 truncates", 0, 0);

        // 6: randomized run with a mid-run reset pulse
        for (int k = 0; k < 160; k++) begin
            do_op($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
                  8'($urandom_range(0, 255)));
            if (k == 80) begin
                #2;
                rst = 1'b1;
                @(posedge clk); #1;
                expect_regs("random rst", 0, 0);
                @(negedge clk); #2;
                rst = 1'b0;
            end
        end

        @(negedge clk); #1;
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
